// File: rtl/flick_conditioner.sv
// Flick button conditioner: 2-flop sync, press/release debounce FSM.
// Define FLICK_REPEAT_EN to add auto-repeat pulses while held.
module flick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flick_raw,
    output logic flick_level,
    output logic flick_pulse,
    output logic flick_release
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          r_pulse;
    logic          r_release;
    logic          w_level_nxt;
    logic          w_pulse_nxt;
    logic          w_press_acc;
    logic          w_release_nxt;
    logic          w_held_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= flick_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_pulse   <= w_pulse_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_acc   = 1'b0;
        w_release_nxt = 1'b0;
        w_held_entry  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt  = HELD;
                    w_press_acc  = 1'b1;
                    w_held_entry = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_CHK: begin
                if (r_sync2) begin
                    w_state_nxt  = HELD;
                    w_held_entry = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Level tracks the debounced state: high from acceptance to release.
        w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_CHK);
    end

`ifdef FLICK_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rep;
    logic          w_rep_hit;

    assign w_rep_hit = (r_state == HELD) && (r_rep == REP_MAX);

    // Frozen outside HELD so a bounced release does not advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep <= '0;
        end else if (w_held_entry) begin
            r_rep <= '0;
        end else if (r_state == HELD) begin
            r_rep <= w_rep_hit ? '0 : r_rep + RW'(1);
        end
    end

    assign w_pulse_nxt = w_press_acc | w_rep_hit;
`else
    assign w_pulse_nxt = w_press_acc;
`endif

    assign flick_level   = r_level;
    assign flick_pulse   = r_pulse;
    assign flick_release = r_release;

endmodule
